// File: rtl/mvm_feeder.sv
// Buffers one matrix+vector frame from an upstream stream and replays it to an MVM engine.
// Optional MVM_FEEDER_REUSE_EN: vector-only frames reuse the previously loaded matrix.
module mvm_feeder #(
    parameter int k = 12,
    parameter int b = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [b-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_reuse,
    output logic                loadMatrix,
    output logic                loadVector,
    output logic                start,
    output logic signed [b-1:0] data_in,
    input  logic                done,
    output logic                busy
);

    localparam int unsigned MW = k * k;
    localparam int unsigned L  = k * k + k;
    localparam int unsigned AW = $clog2(L);

    localparam logic [AW-1:0] LAST_FULL = AW'(L - 1);
    localparam logic [AW-1:0] LAST_VEC  = AW'(k - 1);
    localparam logic [AW-1:0] LAST_MAT  = AW'(MW - 1);
    localparam logic [AW-1:0] VEC_BASE  = AW'(MW);

    localparam logic [2:0] FILL      = 3'd0;
    localparam logic [2:0] LOAD_M    = 3'd1;
    localparam logic [2:0] BURST_M   = 3'd2;
    localparam logic [2:0] LOAD_V    = 3'd3;
    localparam logic [2:0] BURST_V   = 3'd4;
    localparam logic [2:0] START     = 3'd5;
    localparam logic [2:0] WAIT_DONE = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [AW-1:0]       wr_idx_q, rd_idx_q, wr_addr;
    logic                mat_loaded_q, vec_only_q, vec_only, last_word, xfer;
    logic signed [b-1:0] mem [L];

    assign s_ready = (state_q == FILL);
    assign xfer    = s_valid && s_ready;

`ifdef MVM_FEEDER_REUSE_EN
    // Reuse decision is taken on the first word and held for the rest of the frame.
    assign vec_only = (wr_idx_q == '0) ? (s_reuse && mat_loaded_q) : vec_only_q;
`else
    logic unused_reuse;
    assign vec_only     = 1'b0;
    assign unused_reuse = ^{s_reuse, mat_loaded_q, vec_only_q};
`endif

    assign last_word = vec_only ? (wr_idx_q == LAST_VEC) : (wr_idx_q == LAST_FULL);
    // Vector-only frames land in the vector slots so BURST_V reads one fixed region.
    assign wr_addr   = vec_only ? (wr_idx_q + VEC_BASE) : wr_idx_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:      if (xfer && last_word) state_d = vec_only ? LOAD_V : LOAD_M;
            LOAD_M:    state_d = BURST_M;
            BURST_M:   if (rd_idx_q == LAST_MAT) state_d = LOAD_V;
            LOAD_V:    state_d = BURST_V;
            BURST_V:   if (rd_idx_q == LAST_FULL) state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (done) state_d = FILL;
            default:   state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            mat_loaded_q <= 1'b0;
            vec_only_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                wr_idx_q <= last_word ? '0 : wr_idx_q + 1'b1;
                if (wr_idx_q == '0) vec_only_q <= vec_only;
            end
            case (state_q)
                LOAD_M:           rd_idx_q <= '0;
                LOAD_V:           rd_idx_q <= VEC_BASE;
                BURST_M, BURST_V: rd_idx_q <= rd_idx_q + 1'b1;
                default:          rd_idx_q <= rd_idx_q;
            endcase
            if (state_q == BURST_M && rd_idx_q == LAST_MAT) mat_loaded_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) mem[wr_addr] <= s_data;
    end

    always_comb begin
        loadMatrix = (state_q == LOAD_M);
        loadVector = (state_q == LOAD_V);
        start      = (state_q == START);
        busy       = (state_q != FILL);
        data_in    = '0;
        if (state_q == BURST_M || state_q == BURST_V) data_in = mem[rd_idx_q];
    end

endmodule

// File: tb/tb_mvm_feeder.sv
// Randomized scoreboard bench for mvm_feeder; expected output traces are built per frame.
module tb_mvm_feeder;

    localparam int K = 12;
    localparam int B = 12;
    localparam int L = K * K + K;

    typedef struct {
        logic         lm;
        logic         lv;
        logic         st;
        logic [B-1:0] d;
        bit           first;
    } ent_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [B-1:0] s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic                s_reuse = 1'b0;
    logic                lm, lv, st;
    logic signed [B-1:0] data_in;
    logic                done = 1'b0;
    logic                busy;

    mvm_feeder #(.k(K), .b(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_reuse    (s_reuse),
        .loadMatrix (lm),
        .loadVector (lv),
        .start      (st),
        .data_in    (data_in),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    ent_t exp_q[$];
    int   lat_q[$];
    bit   tracking = 1'b0;
    bit   mat_m = 1'b0;
    logic signed [B-1:0] words[$];
    ent_t e;

    function automatic void check(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic void push_ent(logic m, logic v, logic s, logic [B-1:0] d, bit f);
        ent_t x;
        x.lm = m; x.lv = v; x.st = s; x.d = d; x.first = f;
        exp_q.push_back(x);
    endfunction

    // Reference: what the downstream MVM must see for the frame held in words[].
    function automatic void model_push(bit vo);
        int base;
        if (!vo) begin
            push_ent(1, 0, 0, '0, 1);
            for (int i = 0; i < K * K; i++) push_ent(0, 0, 0, words[i], 0);
            push_ent(0, 1, 0, '0, 0);
        end else begin
            push_ent(0, 1, 0, '0, 1);
        end
        base = vo ? 0 : K * K;
        for (int i = 0; i < K; i++) push_ent(0, 0, 0, words[base + i], 0);
        push_ent(0, 0, 1, '0, 0);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            lat_q.delete();
            tracking = 1'b0;
        end else if (tracking || lm || lv || st) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'({lm, lv, st}), 0);
                tracking = 1'b0;
            end else begin
                e = exp_q.pop_front();
                check("out_trace", int'({lm, lv, st, data_in}), int'({e.lm, e.lv, e.st, e.d}));
                check("busy_active", int'(busy), 1);
                if (e.first) begin
                    if (lat_q.size() == 0) check("latency_missing", 1, 0);
                    else check("first_pulse_latency", cyc, lat_q.pop_front());
                end
                tracking = !e.st;
            end
        end else begin
            check("idle_data_zero", int'(data_in), 0);
        end
    end

    task automatic send(input int n, input bit reuse, input int mode, input bit expect_lat);
        bit tog = 1'b1;
        int i = 0;
        int guard = 0;
        while (i < n && guard < 4 * n + 20) begin
            @(posedge clk); #1;
            case (mode)
                0:       s_valid = 1'b1;
                1:       begin s_valid = tog; tog = !tog; end
                default: s_valid = ($urandom_range(0, 2) != 0);
            endcase
            s_data  = words[i];
            s_reuse = reuse;
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (expect_lat && i == n - 1) lat_q.push_back(cyc + 1);
                i++;
            end
            guard++;
        end
        check("fill_complete", i, n);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_reuse = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_pulse(input bit want_start);
        bit found = 1'b0;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (want_start ? st : (lm || lv)) begin
                found = 1'b1;
                break;
            end
        end
        check(want_start ? "start_timeout" : "load_timeout", int'(found), 1);
    endtask

    task automatic finish_frame();
        wait_pulse(1'b1);
        repeat (3) @(negedge clk);
        check("wait_busy", int'(busy), 1);
        check("wait_s_ready", int'(s_ready), 0);
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        check("post_done_s_ready", int'(s_ready), 1);
        check("post_done_busy", int'(busy), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        mat_m = 1'b0;
        @(negedge clk);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({lm, lv, st}), 0);
        check("rst_data_in", int'(data_in), 0);
    endtask

    task automatic fill_words(input int n, input int dkind);
        words.delete();
        for (int i = 0; i < n; i++) begin
            case (dkind)
                0:       words.push_back(B'(i + 1));
                1:       words.push_back(B'(-(i + 1)));
                default: words.push_back(B'($urandom));
            endcase
        end
    endtask

    task automatic run_frame(input bit reuse, input int mode, input int dkind, input bit stray_done);
        bit vo;
`ifdef MVM_FEEDER_REUSE_EN
        vo = reuse && mat_m;
`else
        vo = 1'b0;
`endif
        fill_words(vo ? K : L, dkind);
        model_push(vo);
        send(vo ? K : L, reuse, mode, 1'b1);
        if (stray_done) begin
            wait_pulse(1'b0);
            repeat (10) @(posedge clk);
            #1 done = 1'b1;
            @(posedge clk); #1 done = 1'b0;
        end
        finish_frame();
        if (!vo) mat_m = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // s_reuse on the first frame after reset must be ignored.
        run_frame(1'b1, 0, 0, 1'b0);
        // Alternating valid, plus a stray done during the matrix burst.
        run_frame(1'b0, 1, 0, 1'b1);
`ifdef MVM_FEEDER_REUSE_EN
        run_frame(1'b1, 0, 1, 1'b0);
`endif
        // Reset in the middle of the matrix burst, then a full replay.
        fill_words(L, 0);
        model_push(1'b0);
        send(L, 1'b0, 0, 1'b1);
        wait_pulse(1'b0);
        repeat (50) @(negedge clk);
        do_reset();
        run_frame(1'b0, 0, 0, 1'b0);
        // Reset part way through filling.
        fill_words(70, 2);
        send(70, 1'b0, 2, 1'b0);
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(1'($urandom_range(0, 1)), 2, 2, 1'b0);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
